// File: rtl/kseq_pkg.sv
// Shared definitions for the keystream sequencer: state encoding and default sizes.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package kseq_pkg;

  localparam int KSEQ_WARMUP_DEF = 16;
  localparam int KSEQ_LEN_W_DEF  = 16;
  localparam int KSEQ_STATE_W    = 3;
  // Warm-up counters must hold any WARMUP in 1..65535 regardless of LEN_W.
  localparam int KSEQ_WARM_W     = 16;

  typedef enum logic [KSEQ_STATE_W-1:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WARM  = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4,
    S_FIN   = 3'd5
  } kseq_state_e;

  // Core words are routed to the output buffer only once warm-up is over.
  function automatic logic is_routing(kseq_state_e s);
    return (s == S_RUN) || (s == S_DRAIN);
  endfunction

endpackage

// File: rtl/keystream_sequencer_if.sv
// Bundles the session request, core control and downstream valid/ready signals.
// Latency: n/a (wiring only).
// Backpressure: out_ready from the consumer side, carried unchanged.
interface keystream_sequencer_if #(
  parameter int LEN_W = kseq_pkg::KSEQ_LEN_W_DEF
);

  logic             start;
  logic [LEN_W-1:0] msg_len;
  logic             seed_load;
  logic             core_en;
  logic             core_valid;
  logic             out_valid;
  logic             out_ready;
  logic             ks_sel;
  logic             busy;
  logic             done;

  // Sequencer side.
  modport slave (
    input  start, msg_len, core_valid, out_ready,
    output seed_load, core_en, out_valid, ks_sel, busy, done
  );

  // Controller / core / consumer side.
  modport master (
    output start, msg_len, core_valid, out_ready,
    input  seed_load, core_en, out_valid, ks_sel, busy, done
  );

endinterface

// File: rtl/kseq_outbuf.sv
// One-entry valid/ready holding slot for a keystream word.
// Latency: a loaded word is visible the cycle after load.
// Backpressure: valid holds until ready; a load in the handshake cycle keeps valid high.
module kseq_outbuf (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic flush,
  input  logic ready,
  output logic valid
);

  // Flush beats load beats drain, so a refill during the handshake never drops valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/keystream_sequencer.sv
// Seeds the chaotic core, discards WARMUP words, then streams msg_len keystream words.
// Latency: start->seed_load 1 cycle; done pulses the cycle after the final handshake.
// Backpressure: one word in flight; no core issue while the output slot is stuck.
// Build option KSEQ_ABORT_EN adds an abort input that ends any active session.
module keystream_sequencer
  import kseq_pkg::*;
#(
  parameter int WARMUP = KSEQ_WARMUP_DEF,
  parameter int LEN_W  = KSEQ_LEN_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef KSEQ_ABORT_EN
  input  logic                 abort,
`endif
  keystream_sequencer_if.slave bus
);

  localparam logic [KSEQ_WARM_W-1:0] WARM_N    = KSEQ_WARM_W'(WARMUP);
  localparam logic [KSEQ_WARM_W-1:0] WARM_LAST = KSEQ_WARM_W'(WARMUP - 1);

  kseq_state_e            state_q;
  kseq_state_e            state_d;
  logic [LEN_W-1:0]       len_cnt;
  logic [LEN_W-1:0]       iss_cnt;
  logic [KSEQ_WARM_W-1:0] warm_cnt;
  logic [KSEQ_WARM_W-1:0] warm_iss;
  logic                   pend_q;
  logic                   core_en;
  logic                   out_valid;
  logic                   abort_hit;

`ifdef KSEQ_ABORT_EN
  assign abort_hit = abort && (state_q != S_IDLE) && (state_q != S_FIN);
`else
  assign abort_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and core issue decode.
  always_comb begin
    state_d = state_q;
    core_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = (bus.msg_len != '0) ? S_LOAD : S_FIN;
        end
      end
      S_LOAD: state_d = S_WARM;
      S_WARM: begin
        // Warm-up issues are pipelined; leave once the last discard arrives.
        core_en = (warm_iss != WARM_N);
        if (bus.core_valid && (warm_cnt == WARM_LAST)) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Issue only when the returning word is certain to find room.
        core_en = (iss_cnt < len_cnt) && !pend_q && (!out_valid || bus.out_ready);
        if (iss_cnt == len_cnt) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_valid && bus.out_ready && !pend_q) begin
          state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_hit) begin
      state_d = S_FIN;
      core_en = 1'b0;
    end
  end

  // Session counters and the outstanding-word flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_cnt  <= '0;
      iss_cnt  <= '0;
      warm_cnt <= '0;
      warm_iss <= '0;
      pend_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Length is captured at acceptance so later msg_len changes are ignored.
          if (bus.start) begin
            len_cnt <= bus.msg_len;
          end
        end
        S_LOAD: begin
          iss_cnt  <= '0;
          warm_cnt <= '0;
          warm_iss <= '0;
          pend_q   <= 1'b0;
        end
        S_WARM: begin
          if (core_en) begin
            warm_iss <= warm_iss + KSEQ_WARM_W'(1);
          end
          if (bus.core_valid) begin
            warm_cnt <= warm_cnt + KSEQ_WARM_W'(1);
          end
        end
        S_RUN, S_DRAIN: begin
          if (core_en) begin
            iss_cnt <= iss_cnt + LEN_W'(1);
            pend_q  <= 1'b1;
          end else if (bus.core_valid) begin
            pend_q <= 1'b0;
          end
        end
        default: ;
      endcase
      if (abort_hit) begin
        pend_q <= 1'b0;
      end
    end
  end

  kseq_outbuf u_outbuf (
    .clk   (clk),
    .reset (reset),
    .load  (bus.core_valid && is_routing(state_q) && !abort_hit),
    .flush (abort_hit),
    .ready (bus.out_ready),
    .valid (out_valid)
  );

  assign bus.seed_load = (state_q == S_LOAD);
  assign bus.core_en   = core_en;
  assign bus.out_valid = out_valid;
  assign bus.ks_sel    = is_routing(state_q);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_FIN);

endmodule

// File: tb/tb_keystream_sequencer.sv
// Bench for keystream_sequencer with a latency-configurable core model and a word scoreboard.
// Latency: n/a.
// Backpressure: out_ready driven constant, random, or stalled per scenario.
module tb_keystream_sequencer;

  localparam int WARMUP = 4;
  localparam int LEN_W  = 4;

  logic clk = 1'b0;
  logic reset;
`ifdef KSEQ_ABORT_EN
  logic abort_i;
`endif

  always #5 clk = ~clk;

  keystream_sequencer_if #(.LEN_W(LEN_W)) bus ();

  keystream_sequencer #(.WARMUP(WARMUP), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .reset (reset),
`ifdef KSEQ_ABORT_EN
    .abort (abort_i),
`endif
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int lat    = 1;

  // Core model: response cycle of each issued request.  Scoreboard: ids of buffered words.
  int due[$];
  int prod[$];
  int next_id, kept_id;

  int s_seeds, s_warm_en, s_run_en, s_disc, s_kept, s_hs, s_dones, s_done_cyc;
  int s_last_hs, s_start_cyc, s_viol, s_order, s_stall_en, s_abort_cyc, s_ov_seen, s_noise;
  bit s_busy_after, s_last_busy, s_last_done, s_stalling, s_timeout;

  // Observe one cycle's outputs (called at the falling edge).
  task automatic observe();
    if (s_dones != 0 && cyc == s_done_cyc + 1) s_busy_after = bus.busy;
    if (bus.seed_load) s_seeds++;
    if (bus.done) begin s_dones++; s_done_cyc = cyc; end
    if (bus.out_valid) s_ov_seen++;
    // Buffer occupancy must match words produced minus words accepted.
    if (bus.out_valid !== (prod.size() != 0)) s_viol++;
    if (bus.core_en) begin
      if (bus.ks_sel) begin
        s_run_en++;
        if (due.size() != 0 || (bus.out_valid && !bus.out_ready)) s_viol++;
      end else begin
        s_warm_en++;
      end
      if (s_stalling) s_stall_en++;
      due.push_back(cyc + lat);
    end
    if (bus.out_valid && bus.out_ready) begin
      s_hs++;
      s_last_hs = cyc;
      if (prod.size() == 0) s_viol++;
      else if (prod.pop_front() != next_id) s_order++;
      next_id++;
    end
    if (bus.core_valid) begin
      if (bus.ks_sel) begin
        prod.push_back(kept_id);
        kept_id++;
        s_kept++;
        if (prod.size() > 1) s_viol++;
      end else begin
        s_disc++;
      end
    end
    s_last_busy = bus.busy;
    s_last_done = bus.done;
  endtask

  task automatic tick();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    cyc++;
    bus.core_valid = (due.size() != 0) && (due[0] == cyc);
    if (bus.core_valid) void'(due.pop_front());
  endtask

  task automatic run_session(input int len, input int lat_i, input bit rnd_ready, input bit stall,
                             input bit noise, input int rst_after_hs, input bit abort_warm);
    int n = 0;
    int stall_left = 10;
    bit abort_sent = 1'b0;
    s_seeds = 0; s_warm_en = 0; s_run_en = 0; s_disc = 0; s_kept = 0; s_hs = 0; s_dones = 0;
    s_done_cyc = -10; s_last_hs = -10; s_viol = 0; s_order = 0; s_stall_en = 0;
    s_abort_cyc = -10; s_ov_seen = 0; s_noise = 0;
    s_busy_after = 1'b1; s_last_busy = 1'b0; s_last_done = 1'b0; s_stalling = 1'b0; s_timeout = 1'b0;
    prod.delete();
    next_id = 0; kept_id = 0; lat = lat_i;
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    bus.msg_len   = LEN_W'(len);
    s_start_cyc   = cyc;
    tick();
    bus.start = 1'b0;
    if (noise) bus.msg_len = LEN_W'($urandom);
    while (!(s_dones != 0 && cyc > s_done_cyc + 1)) begin
      if (rst_after_hs > 0 && s_hs >= rst_after_hs) break;
      if (n >= 3000) begin s_timeout = 1'b1; break; end
      n++;
      s_stalling = 1'b0;
      if (stall && s_hs >= 2 && stall_left > 0) begin
        bus.out_ready = 1'b0; stall_left--; s_stalling = 1'b1;
      end else if (rnd_ready) begin
        bus.out_ready = ($urandom_range(0, 9) < 6);
      end else begin
        bus.out_ready = 1'b1;
      end
      bus.start = noise && s_last_busy && !s_last_done && ($urandom_range(0, 2) == 0);
      if (bus.start) s_noise++;
`ifdef KSEQ_ABORT_EN
      abort_i = 1'b0;
      if (abort_warm && s_seeds != 0 && !abort_sent) begin
        abort_i = 1'b1; abort_sent = 1'b1; s_abort_cyc = cyc;
      end
`else
      if (abort_warm) abort_sent = 1'b1;
`endif
      tick();
    end
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
`ifdef KSEQ_ABORT_EN
    abort_i = 1'b0;
`endif
  endtask

  task automatic test_reset();
    logic [5:0] outs;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    outs = {bus.seed_load, bus.core_en, bus.out_valid, bus.ks_sel, bus.busy, bus.done};
    checks++;
    if (outs !== 6'b0) begin errors++; $display("FAIL reset_outs got %b want 000000", outs); end
    @(posedge clk); #1;
    reset = 1'b1;
    tick();
    @(negedge clk);
    outs = {bus.seed_load, bus.core_en, bus.out_valid, bus.ks_sel, bus.busy, bus.done};
    checks++;
    if (outs !== 6'b0) begin errors++; $display("FAIL idle_outs got %b want 000000", outs); end
    @(posedge clk); #1; cyc++;
  endtask

  task automatic test_basic();
    run_session(3, 1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    checks++; if (s_seeds !== 1) begin errors++; $display("FAIL basic_seed got %0d want 1", s_seeds); end
    checks++; if (s_disc !== WARMUP) begin errors++; $display("FAIL basic_discards got %0d want %0d", s_disc, WARMUP); end
    checks++; if (s_warm_en !== WARMUP) begin errors++; $display("FAIL basic_warm_issues got %0d want %0d", s_warm_en, WARMUP); end
    checks++; if (s_hs !== 3) begin errors++; $display("FAIL basic_handshakes got %0d want 3", s_hs); end
    checks++; if (s_done_cyc !== s_last_hs + 1) begin errors++; $display("FAIL basic_done_time got %0d want %0d", s_done_cyc, s_last_hs + 1); end
    checks++; if (s_dones !== 1) begin errors++; $display("FAIL basic_done_count got %0d want 1", s_dones); end
    checks++; if (s_busy_after !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %0d want 0", s_busy_after); end
    checks++; if (s_viol !== 0 || s_timeout) begin errors++; $display("FAIL basic_protocol got %0d want 0", s_viol + s_timeout); end
  endtask

  task automatic test_zero_len();
    run_session(0, 1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    checks++; if (s_seeds !== 0) begin errors++; $display("FAIL zero_seed got %0d want 0", s_seeds); end
    checks++; if (s_warm_en + s_run_en !== 0) begin errors++; $display("FAIL zero_core_en got %0d want 0", s_warm_en + s_run_en); end
    checks++; if (s_dones !== 1) begin errors++; $display("FAIL zero_done_count got %0d want 1", s_dones); end
    checks++;
    if (s_done_cyc - s_start_cyc < 1 || s_done_cyc - s_start_cyc > 2) begin
      errors++; $display("FAIL zero_done_delay got %0d want 1..2", s_done_cyc - s_start_cyc);
    end
  endtask

  task automatic test_stall();
    run_session(5, 1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    checks++; if (s_hs !== 5) begin errors++; $display("FAIL stall_handshakes got %0d want 5", s_hs); end
    checks++; if (s_stall_en !== 0) begin errors++; $display("FAIL stall_core_en got %0d want 0", s_stall_en); end
    checks++; if (s_order !== 0) begin errors++; $display("FAIL stall_order got %0d want 0", s_order); end
    checks++; if (s_viol !== 0 || s_timeout) begin errors++; $display("FAIL stall_protocol got %0d want 0", s_viol + s_timeout); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      int len;
      int l;
      len = (i == 0) ? ((1 << LEN_W) - 1) : int'($urandom_range(1, (1 << LEN_W) - 1));
      l   = int'($urandom_range(1, 3));
      run_session(len, l, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      checks++; if (s_hs !== len) begin errors++; $display("FAIL rand%0d_handshakes got %0d want %0d", i, s_hs, len); end
      checks++; if (s_disc !== WARMUP) begin errors++; $display("FAIL rand%0d_discards got %0d want %0d", i, s_disc, WARMUP); end
      checks++; if (s_done_cyc !== s_last_hs + 1) begin errors++; $display("FAIL rand%0d_done_time got %0d want %0d", i, s_done_cyc, s_last_hs + 1); end
      checks++; if (s_viol + s_order !== 0 || s_timeout) begin errors++; $display("FAIL rand%0d_protocol got %0d want 0", i, s_viol + s_order + s_timeout); end
      checks++; if (s_busy_after !== 1'b0) begin errors++; $display("FAIL rand%0d_busy_after got %0d want 0", i, s_busy_after); end
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] outs;
    run_session(8, 1, 1'b0, 1'b0, 1'b0, 2, 1'b0);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got %0d want 1", bus.busy); end
    reset = 1'b0;
    #1;
    outs = {bus.seed_load, bus.core_en, bus.out_valid, bus.ks_sel, bus.busy, bus.done};
    checks++;
    if (outs !== 6'b0) begin errors++; $display("FAIL midrst_outs got %b want 000000", outs); end
    due.delete();
    bus.core_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; cyc++; end
    reset = 1'b1;
    tick();
    run_session(8, 1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    checks++; if (s_seeds !== 1) begin errors++; $display("FAIL midrst_seed got %0d want 1", s_seeds); end
    checks++; if (s_hs !== 8) begin errors++; $display("FAIL midrst_handshakes got %0d want 8", s_hs); end
    checks++; if (s_viol !== 0 || s_timeout) begin errors++; $display("FAIL midrst_protocol got %0d want 0", s_viol + s_timeout); end
  endtask

  task automatic test_back_to_back();
    int t_clean;
    run_session(6, 2, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    t_clean = s_done_cyc - s_start_cyc;
    run_session(6, 2, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    checks++; if (s_done_cyc - s_start_cyc !== t_clean) begin errors++; $display("FAIL noise_timing got %0d want %0d", s_done_cyc - s_start_cyc, t_clean); end
    checks++; if (s_hs !== 6) begin errors++; $display("FAIL noise_handshakes got %0d want 6", s_hs); end
    checks++; if (s_seeds !== 1) begin errors++; $display("FAIL noise_seed got %0d want 1", s_seeds); end
  endtask

`ifdef KSEQ_ABORT_EN
  task automatic test_abort();
    run_session(5, 2, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    checks++; if (s_done_cyc !== s_abort_cyc + 1) begin errors++; $display("FAIL abort_done_time got %0d want %0d", s_done_cyc, s_abort_cyc + 1); end
    checks++; if (s_dones !== 1) begin errors++; $display("FAIL abort_done_count got %0d want 1", s_dones); end
    checks++; if (s_ov_seen !== 0) begin errors++; $display("FAIL abort_out_valid got %0d want 0", s_ov_seen); end
  endtask
`endif

  initial begin
    reset          = 1'b0;
    bus.start      = 1'b0;
    bus.msg_len    = '0;
    bus.core_valid = 1'b0;
    bus.out_ready  = 1'b1;
`ifdef KSEQ_ABORT_EN
    abort_i        = 1'b0;
`endif
    test_reset();
    test_basic();
    test_zero_len();
    test_stall();
    test_random();
    test_reset_mid();
    test_back_to_back();
`ifdef KSEQ_ABORT_EN
    test_abort();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
